// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, ALU op codes and forward-select codes for the RV32I pipeline
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/or/slt with a zero flag; unused op codes yield 0
module alu import pipeline_pkg::*; #(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);
  // operation select; arithmetic wraps naturally at XLEN bits
  always_comb begin
    Result = ALUControl == ALU_ADD ? SrcA + SrcB :
             ALUControl == ALU_SUB ? SrcA - SrcB :
             ALUControl == ALU_AND ? SrcA & SrcB :
             ALUControl == ALU_OR  ? SrcA | SrcB :
             ALUControl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)} :
             '0;
  end
  assign Zero = Result == '0;
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: RV32I execute stage with forwarding (EXEC_FORWARDING_EN), ALU, beq resolution and E/M register
module execute_cycle import pipeline_pkg::*; #(
  parameter int XLEN = pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  ALUSrcE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic                  ValidE,
  input  logic [2:0]            ALUControlE,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  StallM,
  input  logic                  FlushM,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic                  ValidM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       ALU_ResultM
);
  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_result;
  logic            zero;
`ifdef EXEC_FORWARDING_EN
  assign fwd_a = ForwardA_E == FWD_WB ? ResultW : ForwardA_E == FWD_MEM ? ALU_ResultM : RD1_E;
  assign fwd_b = ForwardB_E == FWD_WB ? ResultW : ForwardB_E == FWD_MEM ? ALU_ResultM : RD2_E;
`else
  logic fwd_unused;
  assign fwd_unused = ^{ForwardA_E, ForwardB_E, ResultW};
  assign fwd_a = RD1_E;
  assign fwd_b = RD2_E;
`endif
  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  alu #(.XLEN(XLEN)) u_alu (
    .SrcA(fwd_a),
    .SrcB(src_b),
    .ALUControl(ALUControlE),
    .Result(alu_result),
    .Zero(zero)
  );
  assign PCSrcE = BranchE & zero & ValidE;
  assign PCTargetE = PCE + Imm_Ext_E;
  // E/M register: reset and flush clear everything, stall holds, otherwise load
  always_ff @(posedge clk) begin
    if (rst || FlushM) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      ValidM      <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (!StallM) begin
      RegWriteM   <= RegWriteE & ValidE;
      MemWriteM   <= MemWriteE & ValidE;
      ResultSrcM  <= ResultSrcE;
      ValidM      <= ValidE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end
endmodule
